// File: rtl/display_scan_4dig_pkg.sv
// Shared constants for the 4-digit scanned 7-segment display: segment codes,
// digit index encoding and the legal count ranges of the two cascaded counters.
package display_scan_4dig_pkg;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_e;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int unsigned MAX_A = 11;
  localparam int unsigned MAX_B = 10;

endpackage

// File: rtl/display_scan_4dig_seg7_decode.sv
// Combinational digit-to-segment decoder; dash wins over blank, blank over the digit.
module display_scan_4dig_seg7_decode
  import display_scan_4dig_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_dash) begin
      o_seg = SEG_DASH;
    end else if (!i_blank) begin
      case (i_code)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/display_scan_4dig.sv
// Time-multiplexed 4-digit 7-segment driver showing two counts as tens/units pairs,
// with a once-per-frame snapshot so a frame never mixes old and new counts.
module display_scan_4dig
  import display_scan_4dig_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_a,
  input  logic [3:0] cnt_b,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int unsigned     PreW     = $clog2(REFRESH_DIV);
  localparam logic [PreW-1:0] PreLast  = PreW'(REFRESH_DIV - 1);
  localparam logic [6:0]      SegOff   = {7{ACTIVE_LOW_SEG}};
  localparam logic [3:0]      AnOff    = {4{ACTIVE_LOW_AN}};

  logic [PreW-1:0] r_pre;
  dig_e            r_dig;
  logic [3:0]      r_snap_a;
  logic [3:0]      r_snap_b;

  logic            w_tick;
  logic            w_load;
  dig_e            w_dig_d;
  logic [3:0]      w_snap_a_d;
  logic [3:0]      w_snap_b_d;
  logic [3:0]      w_val;
  logic            w_is_tens;
  logic            w_dash;
  logic [3:0]      w_tens;
  logic [3:0]      w_units;
  logic [3:0]      w_code;
  logic            w_blank;
  logic [6:0]      w_seg_hi;
  logic [3:0]      w_an_hi;

  // Outputs are derived from the next digit index and next snapshot so they
  // change on the same edge as the scan state.
  always_comb begin
    w_tick     = (r_pre == PreLast);
    w_load     = w_tick && (r_dig == DIG3);
    w_dig_d    = w_tick ? dig_e'(r_dig + 2'd1) : r_dig;
    w_snap_a_d = w_load ? cnt_a : r_snap_a;
    w_snap_b_d = w_load ? cnt_b : r_snap_b;
    w_val      = (w_dig_d == DIG0 || w_dig_d == DIG1) ? w_snap_a_d : w_snap_b_d;
    w_is_tens  = (w_dig_d == DIG1 || w_dig_d == DIG3);
    w_dash     = (w_val > 4'(MAX_A));
    w_tens     = (w_val >= 4'd10) ? 4'd1 : 4'd0;
    w_units    = (w_val >= 4'd10) ? (w_val - 4'd10) : w_val;
    w_code     = w_is_tens ? w_tens : w_units;
    w_blank    = blank_lead && w_is_tens && (w_tens == 4'd0);
    w_an_hi    = 4'b0001 << w_dig_d;
  end

  display_scan_4dig_seg7_decode u_decode (
    .i_code  (w_code),
    .i_blank (w_blank),
    .i_dash  (w_dash),
    .o_seg   (w_seg_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre       <= '0;
      r_dig       <= DIG3;
      r_snap_a    <= '0;
      r_snap_b    <= '0;
      seg         <= SegOff;
      dp          <= ACTIVE_LOW_SEG;
      an          <= AnOff;
      frame_start <= 1'b0;
    end else begin
      r_pre       <= w_tick ? '0 : r_pre + 1'b1;
      r_dig       <= w_dig_d;
      r_snap_a    <= w_snap_a_d;
      r_snap_b    <= w_snap_b_d;
      frame_start <= w_load;
      // Display ports only move on a tick, which keeps them dark until the first one.
      if (w_tick) begin
        seg <= w_seg_hi ^ SegOff;
        dp  <= (w_dig_d == DIG2) ^ ACTIVE_LOW_SEG;
        an  <= w_an_hi ^ AnOff;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_4dig.sv
// Directed bench for display_scan_4dig with REFRESH_DIV = 4 and active-low ports.
module tb_display_scan_4dig;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;
  logic       blank_lead;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_start;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  display_scan_4dig #(
    .REFRESH_DIV    (4),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_AN  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b),
    .blank_lead  (blank_lead),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks one digit slot for its full 4 cycles, starting at the negedge after it lights.
  task automatic chk_digit(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic e_fs);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_an%0d", tag, i), {4'h0, an}, {4'h0, e_an});
      chk($sformatf("%s_seg%0d", tag, i), {1'b0, seg}, {1'b0, e_seg});
      chk($sformatf("%s_dp%0d", tag, i), {7'h0, dp}, {7'h0, e_dp});
      chk($sformatf("%s_fs%0d", tag, i), {7'h0, frame_start}, {7'h0, (i == 0) && e_fs});
      @(negedge clk);
    end
  endtask

  // Three dark cycles after reset release, then the negedge where DIG0 is lit.
  task automatic chk_dark(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("%s_an%0d", tag, i), {4'h0, an}, 8'h0F);
      chk($sformatf("%s_seg%0d", tag, i), {1'b0, seg}, 8'h7F);
      chk($sformatf("%s_fs%0d", tag, i), {7'h0, frame_start}, 8'h00);
    end
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    cnt_a      = 4'd7;
    cnt_b      = 4'd3;
    blank_lead = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'h0, dp}, 8'h01);
    chk("rst_fs", {7'h0, frame_start}, 8'h00);

    // Frame 1: a=7, b=3; new counts arrive mid-frame and must not appear yet
    rst = 1'b0;
    chk_dark("rel");
    chk_digit("f1_d0", 4'b1110, 7'h78, 1'b1, 1'b1);
    cnt_a = 4'd11;
    cnt_b = 4'd10;
    chk_digit("f1_d1", 4'b1101, 7'h40, 1'b1, 1'b0);
    chk_digit("f1_d2", 4'b1011, 7'h30, 1'b0, 1'b0);
    chk_digit("f1_d3", 4'b0111, 7'h40, 1'b1, 1'b0);

    // Frame 2: a=11, b=10
    chk_digit("f2_d0", 4'b1110, 7'h79, 1'b1, 1'b1);
    chk_digit("f2_d1", 4'b1101, 7'h79, 1'b1, 1'b0);
    chk_digit("f2_d2", 4'b1011, 7'h40, 1'b0, 1'b0);
    cnt_a      = 4'd5;
    cnt_b      = 4'd0;
    blank_lead = 1'b1;
    chk_digit("f2_d3", 4'b0111, 7'h79, 1'b1, 1'b0);

    // Frame 3: leading-zero blanking, a=5, b=0
    chk_digit("f3_d0", 4'b1110, 7'h12, 1'b1, 1'b1);
    chk_digit("f3_d1", 4'b1101, 7'h7F, 1'b1, 1'b0);
    chk_digit("f3_d2", 4'b1011, 7'h40, 1'b0, 1'b0);
    cnt_a      = 4'd3;
    cnt_b      = 4'd13;
    chk_digit("f3_d3", 4'b0111, 7'h7F, 1'b1, 1'b0);
    blank_lead = 1'b0;

    // Frame 4: a=3, illegal b=13; a changes to 9 during DIG1
    chk_digit("f4_d0", 4'b1110, 7'h30, 1'b1, 1'b1);
    cnt_a = 4'd9;
    chk_digit("f4_d1", 4'b1101, 7'h40, 1'b1, 1'b0);
    chk_digit("f4_d2", 4'b1011, 7'h3F, 1'b0, 1'b0);
    chk_digit("f4_d3", 4'b0111, 7'h3F, 1'b1, 1'b0);

    // Frame 5: a=9 now visible; reset hits mid-DIG2
    chk_digit("f5_d0", 4'b1110, 7'h10, 1'b1, 1'b1);
    chk_digit("f5_d1", 4'b1101, 7'h40, 1'b1, 1'b0);
    chk("f5_d2_an", {4'h0, an}, 8'h0B);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_an", {4'h0, an}, 8'h0F);
    chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
    chk("mid_rst_dp", {7'h0, dp}, 8'h01);
    chk("mid_rst_fs", {7'h0, frame_start}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    chk_dark("rel2");
    chk_digit("f6_d0", 4'b1110, 7'h10, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_scan_4dig.md
Name: display_scan_4dig

Overview:
- Time-multiplexed 4-digit 7-segment driver for the two cascaded counter outputs: the 0-11 count (cnt_a) and the 0-10 count (cnt_b).
- Consumes both 4-bit counts directly and splits each into tens and units digits.
- Scans one digit per refresh period.
- Snapshots both inputs once per frame so a frame is never torn across a counter update.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit; legal range ≥2.
- ACTIVE_LOW_SEG, 1, 1 = seg and dp ports driven active-low (common anode).
- ACTIVE_LOW_AN, 1, 1 = an port driven active-low.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cnt_a  in  4  count 0..11, shown on digits 1:0
- cnt_b  in  4  count 0..10, shown on digits 3:2
- blank_lead  in  1  1 = blank a tens digit whose value is 0
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- an  out  4  digit enables; exactly one active after the first tick
- frame_start  out  1  one-cycle pulse when digit 0 becomes active

Behaviour:
- Prescaler `pre`:
  - width clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (pre == REFRESH_DIV-1).
- Digit index `d` (2 bits), states DIG0..DIG3:
  - On tick, d advances d+1 mod 4 (DIG3 -> DIG0); otherwise d holds.
  - Reset value is DIG3, so the first tick enters DIG0.
- Snapshot:
  - snap_a/snap_b load cnt_a/cnt_b on the tick edge that enters DIG0.
  - Otherwise they hold; input changes mid-frame are not shown until the next frame.
- Digit split per snapshot value v:
  - v 0..9: tens = 0, units = v.
  - v 10: tens 1, units 0.
  - v 11: tens 1, units 1.
  - v 12..15 (illegal): both digits show dash (g only).
- Digit map:
  - an[0] = units(a), an[1] = tens(a), an[2] = units(b), an[3] = tens(b).
  - dp lit only while DIG2 is active (separator between the two pairs).
- Leading-zero blanking: when blank_lead = 1 and the tens value is 0, that digit shows all segments off. The units digit is never blanked.
- Segment codes (internal active-high):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - dash: 40, blank: 00.
  - Port value is the bitwise inverse when ACTIVE_LOW_SEG = 1.
- Output registers:
  - seg, dp, an and frame_start are registered.
  - They are computed from the next d and next snapshot, so they change on the same edge as d; latency from tick to port is 0 additional cycles.
  - frame_start = 1 for exactly the cycle after the edge entering DIG0.
- Reset values (asynchronous, immediate, including mid-frame):
  - pre = 0, d = DIG3, snap_a = snap_b = 0.
  - an all inactive, seg all off, dp off (polarity per parameters), frame_start = 0.
  - First active digit (DIG0) appears REFRESH_DIV edges after rst deasserts.
- Steady state:
  - Each digit is active exactly REFRESH_DIV cycles.
  - Frame period is 4*REFRESH_DIV cycles.
  - Never two an bits active; no cycle with zero active after the first tick.
- blank_lead is sampled combinationally at each digit's output register update; it is not snapshotted.

Decomposition:
- Shared package:
  - the 10 digit segment constants, SEG_DASH and SEG_BLANK;
  - the 2-bit digit index encoding DIG0..DIG3;
  - MAX_A = 11 and MAX_B = 10.
- One sub-module, seg7_decode: combinational 4-bit code plus blank/dash flags -> 7-bit active-high segments.
- Prescaler, scan FSM, snapshot and output registers stay in display_scan_4dig.

Test Plan:
- All tests run with REFRESH_DIV = 4, ACTIVE_LOW_SEG = 1, ACTIVE_LOW_AN = 1.
- Reset release with cnt_a = 7, cnt_b = 3, blank_lead = 0:
  - an = 4'b1111 and seg = 7'h7F for 3 cycles.
  - Then an = 4'b1110, seg = ~07 (7'h78) and frame_start = 1 for one cycle.
- Full frame with cnt_a = 11, cnt_b = 10:
  - an sequence 1110, 1101, 1011, 0111, each 4 cycles.
  - Inverted seg codes, in order: 06, 06, 3F, 06.
  - dp = 0 (lit) only during an = 1011.
- blank_lead = 1 with cnt_a = 5, cnt_b = 0:
  - DIG1 and DIG3 show seg = 7'h7F.
  - DIG0 shows ~6D; DIG2 shows ~3F.
- Mid-frame input change: cnt_a goes 3 -> 9 while DIG1 is active.
  - The rest of that frame shows 3.
  - The next DIG0 shows 9.
- Illegal cnt_b = 13: DIG2 and DIG3 show dash (seg = 7'h3F).
- rst asserted while DIG2 is active:
  - Same cycle: an = 1111, seg = 7F, dp = 1.
  - After release, the scan restarts at DIG0 after 4 cycles.
